// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation controller: FSM state encoding,
// trace-enable bit positions and the default instruction memory depth.
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam int TRACE_REG  = 0;
    localparam int TRACE_MEM  = 1;
    localparam int TRACE_PIPE = 2;

    localparam int DEF_MAX_INSTS = 1024;

    // Load beats are only accepted while the program is still streaming in.
    function automatic logic is_load_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/sim_ctrl_watchdog.sv
// Run-time cycle counter for the simulation controller. Counts only while
// enabled (RUN), saturates at all-ones, and reports the watchdog limit hit
// and whether the trace window has opened.
module sim_watchdog #(
    parameter int CYC_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CYC_W-1:0] i_max_cycles,
    input  logic [CYC_W-1:0] i_trace_start,
    output logic [CYC_W-1:0] o_cycles,
    output logic             o_limit_hit,
    output logic             o_in_window
);

    logic [CYC_W-1:0] r_cycles;
    logic [CYC_W:0]   w_next_wide;

    // One extra bit so the carry out marks saturation and so an all-ones
    // count can never alias a limit match.
    assign w_next_wide = {1'b0, r_cycles} + {{CYC_W{1'b0}}, 1'b1};

    // Saturating cycle counter, cleared on run start and on clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cycles <= '0;
        end else if (i_clr) begin
            r_cycles <= '0;
        end else if (i_en && !w_next_wide[CYC_W]) begin
            r_cycles <= w_next_wide[CYC_W-1:0];
        end
    end

    assign o_cycles    = r_cycles;
    assign o_limit_hit = (i_max_cycles != '0) && (w_next_wide == {1'b0, i_max_cycles});
    assign o_in_window = (r_cycles >= i_trace_start);

endmodule

// File: rtl/sim_ctrl.sv
// Simulation controller: streams the program into instruction memory,
// holds the harts in reset until start, runs them under a watchdog, and
// latches completion / timeout / error status for the testbench.
module sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = DEF_MAX_INSTS,
    parameter int ADDR_W  = 10,
    parameter int N_HARTS = 1,
    parameter int CYC_W   = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_load_valid,
    input  logic [XLEN-1:0]    i_load_data,
    input  logic               i_load_last,
    output logic               o_load_ready,
    input  logic               i_start,
    input  logic [CYC_W-1:0]   i_max_cycles,
    input  logic [CYC_W-1:0]   i_trace_start,
    input  logic [2:0]         i_en_trace,
    input  logic [N_HARTS-1:0] i_hart_ebreak,
    output logic               o_imem_we,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [XLEN-1:0]    o_imem_wdata,
    output logic               o_core_reset,
    output logic [2:0]         o_trace_en,
    output logic [N_HARTS-1:0] o_hart_done,
    output logic               o_finished,
    output logic               o_timeout,
    output logic               o_err,
    output logic [CYC_W-1:0]   o_cycles,
    output logic [ADDR_W:0]    o_load_count
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

    state_t              r_state;
    logic                r_load_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [XLEN-1:0]     r_imem_wdata;
    logic                r_core_reset;
    logic [N_HARTS-1:0]  r_hart_done;
    logic                r_finished;
    logic                r_timeout;
    logic                r_err;
    logic [ADDR_W:0]     r_load_count;

    logic                w_accept;
    logic                w_full;
    logic                w_all_done;
    logic                w_wd_clr;
    logic                w_wd_en;
    logic                w_limit_hit;
    logic                w_in_window;
    logic                w_tracing;

    assign w_accept   = i_load_valid && r_load_ready;
    assign w_full     = (r_load_count == LP_DEPTH);
    assign w_all_done = &(r_hart_done | i_hart_ebreak);

    // The counter restarts whenever a run begins or status is cleared.
    assign w_wd_clr = ((r_state == ST_READY) && i_start) ||
                      (((r_state == ST_HALT) || (r_state == ST_ERR)) && i_clear);
    assign w_wd_en  = (r_state == ST_RUN);

    sim_watchdog #(
        .CYC_W (CYC_W)
    ) u_watchdog (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clr         (w_wd_clr),
        .i_en          (w_wd_en),
        .i_max_cycles  (i_max_cycles),
        .i_trace_start (i_trace_start),
        .o_cycles      (o_cycles),
        .o_limit_hit   (w_limit_hit),
        .o_in_window   (w_in_window)
    );

    // Controller FSM with load path and registered status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_load_ready <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_reset <= 1'b1;
            r_hart_done  <= '0;
            r_finished   <= 1'b0;
            r_timeout    <= 1'b0;
            r_err        <= 1'b0;
            r_load_count <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (i_start) begin
                        // Starting before the program is complete is a protocol error.
                        r_state      <= ST_ERR;
                        r_err        <= 1'b1;
                        r_load_ready <= 1'b0;
                    end else if (w_accept) begin
                        if (w_full) begin
                            // Overflowing beat is dropped, never written.
                            r_state      <= ST_ERR;
                            r_err        <= 1'b1;
                            r_load_ready <= 1'b0;
                        end else begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_load_count[ADDR_W-1:0];
                            r_imem_wdata <= i_load_data;
                            r_load_count <= r_load_count + LP_ONE;
                            if (i_load_last) begin
                                r_state      <= ST_READY;
                                r_load_ready <= 1'b0;
                            end else begin
                                r_state <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_READY: begin
                    if (i_start) begin
                        r_state      <= ST_RUN;
                        r_core_reset <= 1'b0;
                        r_hart_done  <= '0;
                    end
                end
                ST_RUN: begin
                    r_hart_done <= r_hart_done | i_hart_ebreak;
                    // Completion takes priority over a coincident watchdog expiry.
                    if (w_all_done) begin
                        r_state      <= ST_HALT;
                        r_finished   <= 1'b1;
                        r_core_reset <= 1'b1;
                    end else if (w_limit_hit) begin
                        r_state      <= ST_HALT;
                        r_timeout    <= 1'b1;
                        r_core_reset <= 1'b1;
                    end
                end
                ST_HALT, ST_ERR: begin
                    if (i_clear) begin
                        r_state      <= ST_IDLE;
                        r_load_ready <= 1'b1;
                        r_hart_done  <= '0;
                        r_finished   <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_err        <= 1'b0;
                        r_load_count <= '0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_load_ready <= 1'b1;
                    r_core_reset <= 1'b1;
                end
            endcase
        end
    end

    // Trace enables pass through only inside the RUN window.
    assign w_tracing = (r_state == ST_RUN) && w_in_window;
    assign o_trace_en[TRACE_REG]  = w_tracing && i_en_trace[TRACE_REG];
    assign o_trace_en[TRACE_MEM]  = w_tracing && i_en_trace[TRACE_MEM];
    assign o_trace_en[TRACE_PIPE] = w_tracing && i_en_trace[TRACE_PIPE];

    assign o_load_ready = r_load_ready && is_load_state(r_state);
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_core_reset = r_core_reset;
    assign o_hart_done  = r_hart_done;
    assign o_finished   = r_finished;
    assign o_timeout    = r_timeout;
    assign o_err        = r_err;
    assign o_load_count = r_load_count;

endmodule

// File: tb/tb_sim_ctrl.sv
// Testbench for sim_ctrl: small configuration (DEPTH=4, two harts, 8-bit
// cycle counter) so overflow and saturation corners are reachable quickly.
module tb_sim_ctrl;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 2;
    localparam int N_HARTS = 2;
    localparam int CYC_W   = 8;
    localparam int SAT     = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              lv;
    logic [XLEN-1:0]   ld;
    logic              ll;
    logic              st;
    logic [CYC_W-1:0]  mx;
    logic [CYC_W-1:0]  ts;
    logic [2:0]        en;
    logic [N_HARTS-1:0] eb;

    logic              o_load_ready;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [XLEN-1:0]   o_imem_wdata;
    logic              o_core_reset;
    logic [2:0]        o_trace_en;
    logic [N_HARTS-1:0] o_hart_done;
    logic              o_finished;
    logic              o_timeout;
    logic              o_err;
    logic [CYC_W-1:0]  o_cycles;
    logic [ADDR_W:0]   o_load_count;

    int total = 0;
    int bad   = 0;

    sim_ctrl #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .N_HARTS(N_HARTS), .CYC_W(CYC_W)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_clear(clr),
        .i_load_valid(lv), .i_load_data(ld), .i_load_last(ll), .o_load_ready(o_load_ready),
        .i_start(st), .i_max_cycles(mx), .i_trace_start(ts), .i_en_trace(en),
        .i_hart_ebreak(eb),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
        .o_core_reset(o_core_reset), .o_trace_en(o_trace_en), .o_hart_done(o_hart_done),
        .o_finished(o_finished), .o_timeout(o_timeout), .o_err(o_err),
        .o_cycles(o_cycles), .o_load_count(o_load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nw;
        bit         fixed13;
        int         e0;
        int         e1;
        int         mx;
        int         ts;
        logic [2:0] en;
        logic       fin;
        logic       to;
        int         cyc;
        logic [1:0] hd;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " core_reset"}, o_core_reset, 1);
        chk({tag, " load_ready"}, o_load_ready, 1);
        chk({tag, " load_count"}, o_load_count, 0);
        chk({tag, " cycles"},     o_cycles, 0);
        chk({tag, " hart_done"},  o_hart_done, 0);
        chk({tag, " imem_we"},    o_imem_we, 0);
        chk({tag, " imem_addr"},  o_imem_addr, 0);
        chk({tag, " imem_wdata"}, o_imem_wdata, 0);
        chk({tag, " trace_en"},   o_trace_en, 0);
        chk({tag, " finished"},   o_finished, 0);
        chk({tag, " timeout"},    o_timeout, 0);
        chk({tag, " err"},        o_err, 0);
    endtask

    // Called at a negedge in IDLE/LOAD; streams n beats back to back.
    task automatic do_load(input int n, input bit with_last, input bit fixed13, input int base);
        logic [XLEN-1:0] w;
        for (int k = 0; k < n; k++) begin
            chk("load_ready before beat", o_load_ready, 1);
            w  = fixed13 ? 32'h0000_0013 : XLEN'($urandom);
            lv = 1'b1;
            ld = w;
            ll = with_last && (k == n - 1);
            tick();
            chk("imem_we after beat", o_imem_we, 1);
            chk("imem_addr", o_imem_addr, base + k);
            chk("imem_wdata", o_imem_wdata, w);
            chk("load_count", o_load_count, base + k + 1);
            chk("core_reset while loading", o_core_reset, 1);
        end
        lv = 1'b0;
        ll = 1'b0;
        tick();
        chk("imem_we idle", o_imem_we, 0);
        if (with_last) chk("load_ready in READY", o_load_ready, 0);
    endtask

    // Load a program, run it with the given ebreak cycles (-1 = never) and
    // check every RUN cycle and the frozen HALT status against a model built
    // from the termination rules. Returns the DUT's frozen status.
    task automatic run_case(input int nw, input bit fixed13, input int e0, input int e1,
                            input int mxv, input int tsv, input logic [2:0] env,
                            output logic a_fin, output logic a_to, output int a_cyc,
                            output logic [1:0] a_hd);
        int d;
        int t;
        bit mfin;
        int mcyc;
        logic [1:0] mhd;
        d    = (e0 >= 0 && e1 >= 0) ? ((e0 > e1) ? e0 : e1) : -1;
        mfin = (d >= 0) && (mxv == 0 || d <= mxv - 1);
        t    = mfin ? d : mxv - 1;
        mcyc = (t + 1 > SAT) ? SAT : t + 1;
        mhd[0] = (e0 >= 0) && (e0 <= t);
        mhd[1] = (e1 >= 0) && (e1 <= t);

        do_load(nw, 1'b1, fixed13, 0);
        // Clear outside HALT/ERR must not disturb READY.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear ignored in READY count", o_load_count, nw);
        chk("clear ignored in READY core_reset", o_core_reset, 1);

        mx = CYC_W'(mxv);
        ts = CYC_W'(tsv);
        en = env;
        st = 1'b1;
        tick();
        st = 1'b0;
        for (int c = 0; c <= t; c++) begin
            int cs;
            logic [1:0] hdm;
            cs = (c > SAT) ? SAT : c;
            hdm[0] = (e0 >= 0) && (e0 < c);
            hdm[1] = (e1 >= 0) && (e1 < c);
            chk("run core_reset", o_core_reset, 0);
            chk("run cycles", o_cycles, cs);
            chk("run hart_done", o_hart_done, hdm);
            chk("run trace_en", o_trace_en, (cs >= tsv) ? env : 3'b000);
            chk("run finished early", o_finished, 0);
            chk("run timeout early", o_timeout, 0);
            eb[0] = (c == e0);
            eb[1] = (c == e1);
            clr   = (c == 1);
            st    = (c == 2);
            tick();
        end
        eb  = '0;
        clr = 1'b0;
        st  = 1'b0;
        chk("halt finished", o_finished, mfin);
        chk("halt timeout", o_timeout, !mfin);
        chk("halt cycles", o_cycles, mcyc);
        chk("halt hart_done", o_hart_done, mhd);
        chk("halt core_reset", o_core_reset, 1);
        a_fin = o_finished;
        a_to  = o_timeout;
        a_cyc = int'(o_cycles);
        a_hd  = o_hart_done;

        // Status stays frozen in HALT regardless of start/ebreak activity.
        st = 1'b1;
        eb = 2'b11;
        repeat (3) tick();
        st = 1'b0;
        eb = '0;
        chk("frozen cycles", o_cycles, mcyc);
        chk("frozen finished", o_finished, mfin);
        chk("frozen hart_done", o_hart_done, mhd);
        chk("frozen trace_en", o_trace_en, 0);
        chk("frozen core_reset", o_core_reset, 1);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear finished", o_finished, 0);
        chk("clear timeout", o_timeout, 0);
        chk("clear cycles", o_cycles, 0);
        chk("clear hart_done", o_hart_done, 0);
        chk("clear load_count", o_load_count, 0);
        chk("clear load_ready", o_load_ready, 1);
    endtask

    initial begin
        logic a_fin;
        logic a_to;
        int   a_cyc;
        logic [1:0] a_hd;

        //            nw fx e0   e1   mx  ts   en      fin to cyc  hd
        tbl[0] = '{4, 1, 10,  10,  0,  0,   3'b111, 1, 0, 11,  2'b11};
        tbl[1] = '{2, 0, 5,   20,  0,  3,   3'b101, 1, 0, 21,  2'b11};
        tbl[2] = '{2, 0, -1,  -1,  50, 0,   3'b010, 0, 1, 50,  2'b00};
        tbl[3] = '{3, 0, 10,  49,  50, 60,  3'b111, 1, 0, 50,  2'b11};
        tbl[4] = '{1, 0, 49,  49,  50, 3,   3'b001, 1, 0, 50,  2'b11};
        tbl[5] = '{2, 0, 3,   -1,  1,  0,   3'b100, 0, 1, 1,   2'b00};
        tbl[6] = '{2, 0, 300, 300, 0,  200, 3'b010, 1, 0, 255, 2'b11};

        rst = 1'b1; clr = 1'b0; lv = 1'b0; ld = '0; ll = 1'b0; st = 1'b0;
        mx = '0; ts = '0; en = '0; eb = '0;
        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        tick();
        chk_reset_values("after reset");

        for (int i = 0; i < 7; i++) begin
            run_case(tbl[i].nw, tbl[i].fixed13, tbl[i].e0, tbl[i].e1, tbl[i].mx, tbl[i].ts,
                     tbl[i].en, a_fin, a_to, a_cyc, a_hd);
            chk($sformatf("vec%0d finished", i), a_fin, tbl[i].fin);
            chk($sformatf("vec%0d timeout", i), a_to, tbl[i].to);
            chk($sformatf("vec%0d cycles", i), a_cyc, tbl[i].cyc);
            chk($sformatf("vec%0d hart_done", i), a_hd, tbl[i].hd);
        end

        for (int r = 0; r < 8; r++) begin
            int a;
            int b;
            int m;
            int tt;
            a  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 120));
            b  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 120));
            m  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 150));
            if ((a < 0 || b < 0) && m == 0) m = int'($urandom_range(1, 150));
            tt = int'($urandom_range(0, 150));
            run_case(int'($urandom_range(1, DEPTH)), 1'b0, a, b, m, tt, 3'($urandom),
                     a_fin, a_to, a_cyc, a_hd);
        end

        // Overflow: four beats fill memory, the fifth is dropped and errors.
        do_load(DEPTH, 1'b0, 1'b0, 0);
        chk("full still loading", o_load_ready, 1);
        lv = 1'b1;
        ld = 32'hDEAD_BEEF;
        tick();
        lv = 1'b0;
        chk("overflow err", o_err, 1);
        chk("overflow no write", o_imem_we, 0);
        chk("overflow count held", o_load_count, DEPTH);
        chk("overflow load_ready", o_load_ready, 0);
        chk("overflow core_reset", o_core_reset, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("overflow clear err", o_err, 0);
        chk("overflow clear count", o_load_count, 0);
        chk("overflow clear load_ready", o_load_ready, 1);

        // Start in IDLE is a protocol error.
        st = 1'b1;
        tick();
        st = 1'b0;
        chk("start idle err", o_err, 1);
        chk("start idle core_reset", o_core_reset, 1);
        chk("start idle load_ready", o_load_ready, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("start idle clear", o_err, 0);

        // Start in LOAD is a protocol error.
        do_load(1, 1'b0, 1'b0, 0);
        st = 1'b1;
        tick();
        st = 1'b0;
        chk("start load err", o_err, 1);
        chk("start load core_reset", o_core_reset, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("start load clear count", o_load_count, 0);

        // Asynchronous reset in the middle of a run.
        do_load(2, 1'b1, 1'b0, 0);
        mx = '0; ts = 8'd1; en = 3'b111;
        st = 1'b1;
        tick();
        st = 1'b0;
        eb = 2'b01;
        tick();
        eb = '0;
        repeat (3) tick();
        chk("pre-reset core_reset", o_core_reset, 0);
        chk("pre-reset trace_en", o_trace_en, 3'b111);
        chk("pre-reset hart_done", o_hart_done, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk_reset_values("async reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_reset_values("post async reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sim_ctrl.md
Name: sim_ctrl

Overview:
- Parametrised simulation controller for the multi-hart RISC-V uarch model. It sits between the testbench and the core(s).
- Streams the program into instruction memory over a valid/ready channel and holds the harts in reset while loading.
- Releases the harts on start, counts cycles, and windows the trace enables.
- Detects completion (all harts ebreak) or watchdog timeout, and latches final status for the bench.

Parameters:
- XLEN, 32, instruction/data word width
- DEPTH, 1024, instruction memory depth in words (matches DEF_MAX_INSTS)
- ADDR_W, 10, imem word-address width; must satisfy 2**ADDR_W >= DEPTH
- N_HARTS, 1, number of hart ebreak inputs tracked
- CYC_W, 32, cycle counter width

Ports:
- _clk  in  1  clock
- _reset  in  1  reset, asynchronous, active-high
- _clear  in  1  synchronous return to IDLE from HALT or ERR
- _load_valid  in  1  program word valid
- _load_data  in  XLEN  program word
- _load_last  in  1  marks final word of the program
- load_ready_  out  1  controller accepts a load beat
- _start  in  1  run request
- _max_cycles  in  CYC_W  watchdog limit; 0 = unlimited
- _trace_start  in  CYC_W  first cycle at which tracing is enabled
- _en_trace  in  3  {pipeline, mem, reg} trace requests
- _hart_ebreak  in  N_HARTS  per-hart ebreak pulse/level
- imem_we_  out  1  instruction memory write strobe
- imem_addr_  out  ADDR_W  write word address
- imem_wdata_  out  XLEN  write data
- core_reset_  out  1  reset to harts; active-high
- trace_en_  out  3  gated trace enables
- hart_done_  out  N_HARTS  sticky per-hart ebreak seen
- finished_  out  1  all harts done
- timeout_  out  1  watchdog expired
- err_  out  1  protocol/overflow error
- cycles_  out  CYC_W  cycles spent in RUN, saturating
- load_count_  out  ADDR_W+1  words loaded

Behaviour:
- Clock is _clk. Reset is _reset: asynchronous, active-high.
- Reset values:
  - state = IDLE.
  - core_reset_ = 1.
  - load_count_, cycles_, hart_done_ = 0.
  - load_ready_ = 1.
  - imem_we_, trace_en_, finished_, timeout_, err_ = 0.
  - imem_addr_ and imem_wdata_ = 0.
- States: IDLE, LOAD, READY, RUN, HALT, ERR. core_reset_ = 1 in every state except RUN.
- Load handshake:
  - A beat is accepted when _load_valid && load_ready_.
  - Registered write: imem_we_ = 1 the next cycle, with imem_addr_ = load_count_ (pre-increment) and imem_wdata_ = the accepted data.
  - load_count_ increments on each accepted beat.
- Load transitions:
  - IDLE -> LOAD on the first accepted beat.
  - Any accepted beat with _load_last -> READY.
- load_ready_ = 1 only in IDLE/LOAD.
- Load boundary conditions:
  - A beat offered while load_count_ == DEPTH is not written. The block goes to ERR with err_ = 1.
  - A beat accepted at load_count_ == DEPTH-1 with _load_last is legal.
- Start:
  - _start in READY -> RUN. core_reset_ drops the same edge. cycles_ clears to 0.
  - _start in IDLE/LOAD -> ERR.
  - _start in RUN/HALT is ignored.
- RUN:
  - cycles_ += 1 per cycle and saturates at all-ones.
  - hart_done_[i] is set on _hart_ebreak[i] and stays set.
  - trace_en_ = _en_trace when cycles_ >= _trace_start; otherwise 0. It is 0 outside RUN.
- RUN termination:
  - When (hart_done_ | _hart_ebreak) is all-ones: HALT, finished_ = 1.
  - Otherwise, if _max_cycles != 0 and cycles_ + 1 == _max_cycles: HALT, timeout_ = 1.
  - If both occur on the same cycle, finished_ wins and timeout_ stays 0.
- HALT: core_reset_ = 1. cycles_, hart_done_, finished_ and timeout_ are frozen for readout.
- _clear in HALT/ERR -> IDLE. It clears load_count_, cycles_, hart_done_ and all flags. _clear in other states is ignored.
- _reset asserted mid-load or mid-run: immediate return to reset values. Partially written imem contents are don't-care.

Decomposition:
- Shared package/common header holds:
  - state encoding (3-bit enum);
  - the trace bit indices TRACE_REG=0, TRACE_MEM=1, TRACE_PIPE=2;
  - DEF_MAX_INSTS as the default for DEPTH.
- One natural sub-module, sim_watchdog: saturating cycle counter, limit compare and trace-window compare. It is enabled only in RUN and cleared on start/clear.
- The FSM and load path stay in sim_ctrl.

Test Plan:
- Load 4 words 0x00000013 (last on 4th) -> imem writes at addr 0..3 one cycle after each accept; load_count_ = 4; state READY; core_reset_ = 1.
- After load, _start; assert _hart_ebreak = 1 at cycle 10 (N_HARTS = 1) -> core_reset_ falls on start; finished_ = 1; cycles_ = 11 frozen; timeout_ = 0.
- N_HARTS = 2, _max_cycles = 0; ebreak hart0 at cycle 5, hart1 at cycle 20 -> hart_done_ = 01 then 11; finished_ set only after hart1.
- _max_cycles = 50, no ebreak -> timeout_ = 1 with cycles_ = 50; second case: last ebreak on that same cycle -> finished_ = 1, timeout_ = 0.
- DEPTH = 4; offer 5 beats without last -> 4 writes, 5th beat causes err_ = 1 and state ERR; _clear -> IDLE with load_count_ = 0.
- _trace_start = 3, _en_trace = 3'b101 -> trace_en_ = 0 for cycles 0–2, 101 from cycle 3; _reset mid-run -> all outputs return to reset values asynchronously.
